// File: rtl/mult_sequencer.sv
// Multi-cycle unsigned 32x32->64 shift-add multiply controller driving a shared external adder.
// Optional MULT_ZERO_SKIP_EN: a zero operand finishes straight into DONE with a zero product.
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] ph, ph_next;
    logic [WIDTH-1:0] pl, pl_next;
    logic [WIDTH-1:0] m, m_next;
    logic [5:0]       cnt, cnt_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             carry;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ph    <= '0;
            pl    <= '0;
            m     <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            ph    <= ph_next;
            pl    <= pl_next;
            m     <= m_next;
            cnt   <= cnt_next;
            hi    <= hi_next;
            lo    <= lo_next;
        end
    end

    // Adder operands are gated to zero outside RUN so the shared adder stays quiet.
    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign add_a = busy ? ph : '0;
    assign add_b = (busy && pl[0]) ? m : '0;

    // The adder has no carry-out port, so it is rebuilt from the operand and sum MSBs.
    assign carry = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                   ((add_a[WIDTH-1] | add_b[WIDTH-1]) & ~add_result[WIDTH-1]);

    always_comb begin
        state_next = state;
        ph_next    = ph;
        pl_next    = pl;
        m_next     = m;
        cnt_next   = cnt;
        hi_next    = hi;
        lo_next    = lo;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    ph_next    = '0;
                    pl_next    = multiplier;
                    m_next     = multiplicand;
                    cnt_next   = '0;
                    state_next = RUN;
`ifdef MULT_ZERO_SKIP_EN
                    if (multiplicand == '0 || multiplier == '0) begin
                        hi_next    = '0;
                        lo_next    = '0;
                        state_next = DONE;
                    end
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                ph_next  = {carry, add_result[WIDTH-1:1]};
                pl_next  = {add_result[0], pl[WIDTH-1:1]};
                cnt_next = cnt + 6'd1;
                if (cnt == 6'(WIDTH - 1)) begin
                    hi_next    = ph_next;
                    lo_next    = pl_next;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: the shared adder is modelled here and every
// result is compared against a plain 64-bit multiply and simple latency expectations.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    mult_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_result   (add_result),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    // Stand-in for the CPU's shared Add unit.
    assign add_result = add_a + add_b;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int expectedLatency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 0;
`endif
        return 32;
    endfunction

    // Called right after the accepting edge; counts cycles until done, checking busy and hi/lo hold.
    task automatic waitDone(input int exp_lat, input int pulse_at);
        int n = 0;
        int busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            checkOutput("hiHold", {32'd0, hi}, {32'd0, prev_hi});
            checkOutput("loHold", {32'd0, lo}, {32'd0, prev_lo});
            if (pulse_at >= 0 && n == pulse_at) begin
                start        = 1'b1;
                multiplicand = $urandom;
                multiplier   = $urandom;
            end else if (pulse_at >= 0 && n == pulse_at + 1) begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        checkOutput("latency", 64'(n), 64'(exp_lat));
        checkOutput("busyCycles", 64'(busy_cnt), 64'(exp_lat));
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int pulse_at);
        logic [63:0] product;
        product      = {32'd0, a} * {32'd0, b};
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        tick();
        start = 1'b0;
        waitDone(expectedLatency(a, b), pulse_at);
        checkOutput("hi", {32'd0, hi}, {32'd0, product[63:32]});
        checkOutput("lo", {32'd0, lo}, {32'd0, product[31:0]});
        prev_hi = product[63:32];
        prev_lo = product[31:0];
        tick();
        checkOutput("donePulse", {63'd0, done}, 64'd0);
        checkOutput("idleAddA", {32'd0, add_a}, 64'd0);
        checkOutput("idleAddB", {32'd0, add_b}, 64'd0);
        checkOutput("hiStable", {32'd0, hi}, {32'd0, prev_hi});
    endtask

    task automatic checkResetState();
        checkOutput("rstBusy", {63'd0, busy}, 64'd0);
        checkOutput("rstDone", {63'd0, done}, 64'd0);
        checkOutput("rstHi", {32'd0, hi}, 64'd0);
        checkOutput("rstLo", {32'd0, lo}, 64'd0);
        checkOutput("rstAddA", {32'd0, add_a}, 64'd0);
        checkOutput("rstAddB", {32'd0, add_b}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        checkResetState();
        reset_n = 1'b1;
        tick();

        applyStimulus(32'd7, 32'd6, -1);
        checkOutput("lo7x6", {32'd0, lo}, 64'h2A);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        checkOutput("hiMax", {32'd0, hi}, 64'hFFFFFFFE);
        applyStimulus(32'h12345678, 32'h9ABCDEF0, 10);
        checkOutput("hiIgnore", {32'd0, hi}, 64'h0B00EA4E);
        checkOutput("loIgnore", {32'd0, lo}, 64'h242D2080);

        // Reset in the middle of an operation discards it and clears hi/lo.
        multiplicand = 32'h80000000;
        multiplier   = 32'd2;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checkOutput("midBusy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        tick();
        checkResetState();
        reset_n = 1'b1;
        prev_hi = '0;
        prev_lo = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("noDoneAfterRst", {63'd0, done}, 64'd0);
        end
        applyStimulus(32'h80000000, 32'd2, -1);
        checkOutput("hiShift", {32'd0, hi}, 64'd1);

        // start held high: second operation accepted in the DONE cycle.
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        start        = 1'b1;
        tick();
        multiplicand = 32'd10;
        multiplier   = 32'd10;
        waitDone(32, -1);
        checkOutput("b2bLo1", {32'd0, lo}, 64'd15);
        prev_hi = '0;
        prev_lo = 32'd15;
        tick();
        start = 1'b0;
        checkOutput("b2bDoneFall", {63'd0, done}, 64'd0);
        checkOutput("b2bBusyRise", {63'd0, busy}, 64'd1);
        waitDone(32, -1);
        checkOutput("b2bLo2", {32'd0, lo}, 64'd100);
        prev_lo = 32'd100;
        tick();

        applyStimulus(32'd0, 32'hDEADBEEF, -1);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 3) ra = '0;
            if (i % 5 == 4) rb = '0;
            applyStimulus(ra, rb, (i % 3 == 0) ? int'($urandom_range(0, 29)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
